con_mem_sequencer: RTL and testbench
====================================

Name: con_mem_sequencer

Overview:
- Controller that owns the core's debug console memory port (con_write/con_addr/con_in/con_out) and sequences all accesses to it.
- Accepts single-word write, single-word read and burst-dump commands over a valid/ready command channel.
- Returns read data over a valid/ready response stream.
- Also watches the fetch stream for the halt idiom (same instruction repeated) and flags program completion. Sits between the core and the host/UART loader or a self-checking bench.

Parameters:
- READ_LAT, 1, cycles from con_addr change to valid con_out (block RAM latency), 1..4
- HALT_COUNT, 10, consecutive cycles with unchanged if_inst before halted asserts
- IDLE_ADDR, 10'h3ff, value parked on con_addr when no access is in flight

Ports:
- CLK  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 write, 01 read, 10 dump, 11 reserved
- cmd_addr  in  10  word address
- cmd_len  in  11  dump word count, 1..1024
- cmd_data  in  32  write data
- cmd_be  in  4  write byte enables
- rsp_valid  out  1  response word present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  read word
- rsp_addr  out  10  address of rsp_data
- rsp_last  out  1  final word of read or dump
- con_write  out  4  byte write enables to data memory console port
- con_addr  out  10  console address
- con_in  out  32  console write data
- con_out  in  32  console read data
- if_inst  in  32  core fetch-stage instruction
- halted  out  1  sticky program-done flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async on nrst low): FSM to IDLE. cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, con_write=0, con_addr=IDLE_ADDR, con_in=0, halted=0, busy=0. Halt counter and previous-instruction register are cleared to 0.
- Registered outputs throughout. cmd_ready=1 only in IDLE.
- FSM states: IDLE, WRITE, RD_WAIT, RESP.
- IDLE, on accept:
  - op 00 -> WRITE. Next cycle drives con_addr=cmd_addr, con_in=cmd_data, con_write=cmd_be for exactly 1 cycle, then returns to IDLE. No response is produced.
  - op 01 -> RD_WAIT with remaining=1.
  - op 10 -> RD_WAIT with remaining=cmd_len. If cmd_len==0, the command is accepted and dropped with no response, and the FSM stays in IDLE. Values above 1024 are clamped to 1024.
  - op 11 -> accepted and ignored.
- RD_WAIT: con_addr=cur_addr, con_write=0. Waits READ_LAT cycles, then captures con_out into rsp_data and cur_addr into rsp_addr. Sets rsp_last=(remaining==1) and goes to RESP.
- RESP: rsp_valid=1 and is held stable until rsp_ready.
  - On handshake, if rsp_last -> IDLE (con_addr=IDLE_ADDR, rsp_valid drops the following cycle).
  - Otherwise cur_addr+1 (10-bit, wraps 3ff->000), remaining-1, -> RD_WAIT.
- Single-read latency: accept at cycle N, rsp_valid at N+1+READ_LAT. Dump throughput: one word per READ_LAT+1 cycles with rsp_ready tied high.
- Halt detect runs every cycle, independent of the FSM:
  - if_inst==prev: count+1, saturating at HALT_COUNT. Else count=0.
  - prev<=if_inst.
  - halted sets when count reaches HALT_COUNT and stays set until nrst.
- Reset mid-burst: everything returns to reset values immediately. A partially delivered dump is abandoned and no rsp_last is issued.
- con_write is never nonzero outside WRITE.

Optional Feature:
- CON_CYCLE_COUNT_EN defined: adds output cycle_count [31:0].
  - Cleared on reset; increments every cycle while !halted; freezes when halted sets.
  - Wraps at 2^32.
- Undefined: the port and the counter are absent.

Test Plan:
- Write cmd op=00 addr=5 data=DEADBEEF be=F -> con_write=F, con_addr=5, con_in=DEADBEEF for exactly 1 cycle; no rsp_valid.
- Read cmd op=01 addr=5, memory holds DEADBEEF, READ_LAT=1, rsp_ready=1 -> rsp_valid 2 cycles after accept with rsp_data=DEADBEEF, rsp_addr=5, rsp_last=1.
- Dump op=10 addr=3fe len=4, rsp_ready toggling 1/0 -> four responses at addresses 3fe,3ff,000,001 in order. Data is held stable while stalled; rsp_last only on 001.
- Dump len=0 and op=11 -> accepted in 1 cycle, no response, busy never asserts beyond the accept cycle.
- if_inst constant 00000013 for 10 cycles after varying values -> halted rises on the 10th repeat and stays high after if_inst changes. With CON_CYCLE_COUNT_EN, cycle_count freezes at that value.
- nrst pulsed low during the 2nd word of a 100-word dump -> all outputs at reset values immediately; cmd_ready=1; no further responses.

Source files
------------

// File: rtl/con_mem_sequencer.sv
// con_mem_sequencer: sequences write/read/dump access to the debug console
// memory port and flags program completion from the fetch-stream halt idiom.
//
// Ports:
//   CLK, nrst                 clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only while idle)
//   cmd_op/addr/len/data/be   00 write, 01 read, 10 dump, 11 ignored
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/addr/last        read word, its address, final-word flag
//   con_write/addr/in         console port drive (byte enables, addr, data)
//   con_out                   console read data
//   if_inst                   fetch-stage instruction watched for halt
//   halted                    sticky program-done flag
//   busy                      controller not idle
//   cycle_count               free-running cycle counter until halted
//                             (present only with CON_CYCLE_COUNT_EN)
//
// Optional feature macro: CON_CYCLE_COUNT_EN

module con_mem_sequencer #(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned HALT_COUNT = 10,
    parameter logic [9:0]  IDLE_ADDR  = 10'h3ff
) (
    input  logic        CLK,
    input  logic        nrst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [9:0]  cmd_addr,
    input  logic [10:0] cmd_len,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [9:0]  rsp_addr,
    output logic        rsp_last,
    output logic [3:0]  con_write,
    output logic [9:0]  con_addr,
    output logic [31:0] con_in,
    input  logic [31:0] con_out,
    input  logic [31:0] if_inst,
    output logic        halted,
`ifdef CON_CYCLE_COUNT_EN
    output logic [31:0] cycle_count,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    // RD_WAIT lasts READ_LAT cycles: load READ_LAT-1, capture on zero.
    localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

    localparam int CW = (HALT_COUNT == 0) ? 1 : $clog2(HALT_COUNT + 1);
    localparam logic [CW-1:0] HC = CW'(HALT_COUNT);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_data;
    logic [9:0]    r_rsp_addr;
    logic          r_rsp_last;
    logic [3:0]    r_con_write;
    logic [9:0]    r_con_addr;
    logic [31:0]   r_con_in;
    logic [9:0]    r_cur_addr;
    logic [10:0]   r_remaining;
    logic [2:0]    r_wait;

    logic          w_cmd_ready_nxt;
    logic          w_busy_nxt;
    logic          w_rsp_valid_nxt;
    logic [31:0]   w_rsp_data_nxt;
    logic [9:0]    w_rsp_addr_nxt;
    logic          w_rsp_last_nxt;
    logic [3:0]    w_con_write_nxt;
    logic [9:0]    w_con_addr_nxt;
    logic [31:0]   w_con_in_nxt;
    logic [9:0]    w_cur_addr_nxt;
    logic [10:0]   w_rem_nxt;
    logic [2:0]    w_wait_nxt;

    logic          w_accept;
    logic          w_len_zero;
    logic [10:0]   w_len_clamp;
    logic          w_wait_done;
    logic          w_rsp_hs;

    logic [31:0]   r_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_halted;

    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_len_zero  = (cmd_len == 11'd0);
    assign w_len_clamp = (cmd_len > 11'd1024) ? 11'd1024 : cmd_len;
    assign w_wait_done = (r_wait == 3'd0);
    assign w_rsp_hs    = r_rsp_valid && rsp_ready;

    // State and datapath registers.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_last  <= 1'b0;
            r_con_write <= '0;
            r_con_addr  <= IDLE_ADDR;
            r_con_in    <= '0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_wait      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_con_write <= w_con_write_nxt;
            r_con_addr  <= w_con_addr_nxt;
            r_con_in    <= w_con_in_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_remaining <= w_rem_nxt;
            r_wait      <= w_wait_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (cmd_op)
                        OP_WR:   w_state_nxt = S_WRITE;
                        OP_RD:   w_state_nxt = S_RD_WAIT;
                        OP_DUMP: w_state_nxt = w_len_zero ? S_IDLE
                                                          : S_RD_WAIT;
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WRITE: w_state_nxt = S_IDLE;
            S_RD_WAIT: begin
                if (w_wait_done)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_hs)
                    w_state_nxt = r_rsp_last ? S_IDLE : S_RD_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_last_nxt  = r_rsp_last;
        w_con_write_nxt = '0;
        w_con_addr_nxt  = r_con_addr;
        w_con_in_nxt    = r_con_in;
        w_cur_addr_nxt  = r_cur_addr;
        w_rem_nxt       = r_remaining;
        w_wait_nxt      = r_wait;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (cmd_op)
                        OP_WR: begin
                            w_con_addr_nxt  = cmd_addr;
                            w_con_in_nxt    = cmd_data;
                            w_con_write_nxt = cmd_be;
                        end
                        OP_RD: begin
                            w_cur_addr_nxt = cmd_addr;
                            w_con_addr_nxt = cmd_addr;
                            w_rem_nxt      = 11'd1;
                            w_wait_nxt     = WAIT_INIT;
                        end
                        OP_DUMP: begin
                            if (!w_len_zero) begin
                                w_cur_addr_nxt = cmd_addr;
                                w_con_addr_nxt = cmd_addr;
                                w_rem_nxt      = w_len_clamp;
                                w_wait_nxt     = WAIT_INIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                w_con_addr_nxt = IDLE_ADDR;
            end
            S_RD_WAIT: begin
                if (w_wait_done) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = con_out;
                    w_rsp_addr_nxt  = r_cur_addr;
                    w_rsp_last_nxt  = (r_remaining == 11'd1);
                end else begin
                    w_wait_nxt = r_wait - 3'd1;
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (r_rsp_last) begin
                        w_con_addr_nxt = IDLE_ADDR;
                    end else begin
                        // 10-bit address wraps 3ff -> 000 naturally.
                        w_cur_addr_nxt = r_cur_addr + 10'd1;
                        w_con_addr_nxt = r_cur_addr + 10'd1;
                        w_rem_nxt      = r_remaining - 11'd1;
                        w_wait_nxt     = WAIT_INIT;
                    end
                end
            end
            default: ;
        endcase
    end

    // Halt idiom: the same fetch word repeated HALT_COUNT times.
    always_comb begin
        w_cnt_nxt = '0;
        if (if_inst == r_prev)
            w_cnt_nxt = (r_cnt == HC) ? r_cnt : r_cnt + CW'(1);
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_prev   <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_prev <= if_inst;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == HC)
                r_halted <= 1'b1;
        end
    end

`ifdef CON_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst)
            r_cycle_count <= '0;
        else if (!r_halted)
            r_cycle_count <= r_cycle_count + 32'd1;
    end

    assign cycle_count = r_cycle_count;
`endif

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_last  = r_rsp_last;
    assign con_write = r_con_write;
    assign con_addr  = r_con_addr;
    assign con_in    = r_con_in;
    assign halted    = r_halted;

endmodule

// File: tb/tb_con_mem_sequencer.sv
// Bench for con_mem_sequencer: random and directed commands, response
// scoreboard against a reference memory, halt and reset checks.

module tb_con_mem_sequencer;

    localparam int RL = 1;
    localparam int HC = 10;

    logic        CLK = 1'b0;
    logic        nrst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [9:0]  rsp_addr;
    logic        rsp_last;
    logic [3:0]  con_write;
    logic [9:0]  con_addr;
    logic [31:0] con_in;
    logic [31:0] con_out;
    logic [31:0] if_inst;
    logic        halted;
    logic        busy;
`ifdef CON_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    con_mem_sequencer #(
        .READ_LAT  (RL),
        .HALT_COUNT(HC),
        .IDLE_ADDR (10'h3ff)
    ) dut (
        .CLK        (CLK),
        .nrst       (nrst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .cmd_be     (cmd_be),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_addr   (rsp_addr),
        .rsp_last   (rsp_last),
        .con_write  (con_write),
        .con_addr   (con_addr),
        .con_in     (con_in),
        .con_out    (con_out),
        .if_inst    (if_inst),
        .halted     (halted),
`ifdef CON_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic [9:0]  a;
        logic        l;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [1024];
    logic [31:0] ram [1024];
    logic        ram_init;
    int          total = 0;
    int          bad = 0;
    int          nrsp = 0;
    int          rdy_mode = 0;
    bit          rnd_inst = 1'b1;

    // Console RAM seen by the DUT (read latency 1 counted from the
    // registered con_addr).
    always @(posedge CLK) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
        end else begin
            for (int b = 0; b < 4; b++)
                if (con_write[b])
                    ram[con_addr][8*b +: 8] <= con_in[8*b +: 8];
        end
    end
    assign con_out = ram[con_addr];

    initial forever begin
        @(posedge CLK);
        #1;
        case (rdy_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = ~rsp_ready;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (rnd_inst) if_inst = $urandom;
    end

    // Scoreboard monitor: every presented response must match the head.
    always @(negedge CLK) begin
        if (nrst && rsp_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got a=%h d=%h l=%b want none",
                         rsp_addr, rsp_data, rsp_last);
            end else begin
                if (rsp_data !== q[0].d || rsp_addr !== q[0].a ||
                    rsp_last !== q[0].l) begin
                    bad++;
                    $display("FAIL rsp got a=%h d=%h l=%b want a=%h d=%h l=%b",
                             rsp_addr, rsp_data, rsp_last,
                             q[0].a, q[0].d, q[0].l);
                end
                if (rsp_ready) begin
                    void'(q.pop_front());
                    nrsp++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"},  rsp_data, 0);
        chk({tag, "_rsp_addr"},  rsp_addr, 0);
        chk({tag, "_rsp_last"},  rsp_last, 0);
        chk({tag, "_con_write"}, con_write, 0);
        chk({tag, "_con_addr"},  con_addr, 32'h3ff);
        chk({tag, "_con_in"},    con_in, 0);
        chk({tag, "_halted"},    halted, 0);
        chk({tag, "_busy"},      busy, 0);
    endtask

    // Issue one command (called at posedge+1); returns at posedge+1
    // right after the accepting edge and records the expected responses.
    task automatic send_cmd(input logic [1:0] op, input logic [9:0] addr,
                            input logic [10:0] len, input logic [31:0] data,
                            input logic [3:0] be);
        bit         ok;
        int         n;
        logic [9:0] a;
        exp_t       e;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_data  = data;
        cmd_be    = be;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge CLK);
            if (cmd_ready) ok = 1'b1;
            @(posedge CLK);
            #1;
        end
        cmd_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept got=timeout want=accepted op=%0d", op);
            return;
        end
        case (op)
            2'b00: begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
            end
            2'b01, 2'b10: begin
                n = (op == 2'b01) ? 1 : int'(len);
                if (n > 1024) n = 1024;
                a = addr;
                for (int i = 0; i < n; i++) begin
                    e.d = ref_mem[a];
                    e.a = a;
                    e.l = (i == n - 1);
                    q.push_back(e);
                    a = a + 10'd1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic wait_empty(input string name, input int budget);
        int c = 0;
        while (q.size() != 0 && c < budget) begin
            @(negedge CLK);
            c++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s got pending=%0d want pending=0", name, q.size());
            q.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          rise_k;
        int          cnt_m;
        bit          halt_m;
        logic [31:0] prev_m;
        logic [31:0] v;
`ifdef CON_CYCLE_COUNT_EN
        logic [31:0] cc0;
`endif
        nrst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        cmd_be    = '0;
        rsp_ready = 1'b1;
        if_inst   = 32'h1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ram_init = 1'b1;
        #12;
        chk_reset_vals("rst");
        @(negedge CLK);
        nrst = 1'b1;
        ram_init = 1'b0;
        @(posedge CLK);
        #1;

        // Single write: one-cycle console drive, no response.
        send_cmd(2'b00, 10'd5, 11'd0, 32'hdeadbeef, 4'hf);
        @(negedge CLK);
        chk("wr_con_write", con_write, 32'hf);
        chk("wr_con_addr", con_addr, 32'd5);
        chk("wr_con_in", con_in, 32'hdeadbeef);
        chk("wr_busy", busy, 1);
        chk("wr_cmd_ready", cmd_ready, 0);
        @(negedge CLK);
        chk("wr_con_write_off", con_write, 0);
        chk("wr_con_addr_idle", con_addr, 32'h3ff);
        chk("wr_cmd_ready_back", cmd_ready, 1);
        @(posedge CLK);
        #1;

        // Single read latency: valid at accept+1+RL.
        send_cmd(2'b01, 10'd5, 11'd0, 32'h0, 4'h0);
        for (int i = 0; i < RL; i++) begin
            @(negedge CLK);
            chk("rd_lat_early", rsp_valid, 0);
        end
        @(negedge CLK);
        chk("rd_lat_valid", rsp_valid, 1);
        chk("rd_data", rsp_data, 32'hdeadbeef);
        chk("rd_last", rsp_last, 1);
        wait_empty("rd_drain", 50);

        // Wrapping dump with a stalling consumer.
        rdy_mode = 1;
        send_cmd(2'b10, 10'h3fe, 11'd4, 32'h0, 4'h0);
        wait_empty("dump_wrap", 200);

        // Zero-length dump and reserved op are swallowed in one cycle.
        rdy_mode = 0;
        send_cmd(2'b11, 10'd7, 11'd3, 32'h0, 4'h0);
        @(negedge CLK);
        chk("op11_busy", busy, 0);
        chk("op11_ready", cmd_ready, 1);
        @(posedge CLK);
        #1;
        send_cmd(2'b10, 10'd7, 11'd0, 32'h0, 4'h0);
        repeat (4) begin
            @(negedge CLK);
            chk("len0_busy", busy, 0);
            chk("len0_rsp_valid", rsp_valid, 0);
        end
        @(posedge CLK);
        #1;

        // Oversized dump is clamped to 1024 words.
        send_cmd(2'b10, 10'($urandom), 11'd2000, 32'h0, 4'h0);
        wait_empty("dump_clamp", 5000);

        // Random command mix with a random consumer.
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send_cmd(2'($urandom_range(0, 3)), 10'($urandom_range(0, 15)),
                     11'($urandom_range(0, 5)), $urandom,
                     4'($urandom));
        end
        wait_empty("rand_drain", 400);

        // Halt idiom.
        rdy_mode = 0;
        rnd_inst = 1'b0;
        @(posedge CLK);
        #1;
        prev_m = if_inst;
        cnt_m  = 0;
        halt_m = 1'b0;
        rise_k = -1;
        for (int k = 0; k < 22; k++) begin
            if (k < 5)       v = 32'h1000 + 32'(k);
            else if (k < 19) v = 32'h00000013;
            else             v = 32'h2000 + 32'(k);
            if_inst = v;
            @(posedge CLK);
            if (v == prev_m) begin
                if (cnt_m < HC) cnt_m++;
            end else begin
                cnt_m = 0;
            end
            prev_m = v;
            if (cnt_m == HC) halt_m = 1'b1;
            @(negedge CLK);
            chk("halted", halted, halt_m);
            if (halted && rise_k < 0) begin
                rise_k = k;
`ifdef CON_CYCLE_COUNT_EN
                cc0 = cycle_count;
`endif
            end
        end
        chk("halt_rise_cycle", rise_k, 5 + HC);
`ifdef CON_CYCLE_COUNT_EN
        chk("cycle_count_frozen", cycle_count, cc0);
`endif
        rnd_inst = 1'b1;
        @(posedge CLK);
        #1;

        // Reset during the second word of a long dump.
        base = nrsp;
        send_cmd(2'b10, 10'($urandom), 11'd100, 32'h0, 4'h0);
        for (int c = 0; c < 50 && nrsp < base + 1; c++) @(negedge CLK);
        chk("rst_first_word", nrsp - base, 1);
        @(posedge CLK);
        #3;
        nrst = 1'b0;
        q.delete();
        #1;
        chk_reset_vals("rst_mid");
        @(negedge CLK);
        @(negedge CLK);
        nrst = 1'b1;
        repeat (20) @(negedge CLK);
        chk("rst_after_ready", cmd_ready, 1);
        chk("rst_after_busy", busy, 0);
        chk("rst_after_halted", halted, 0);
        chk("rst_words", nrsp - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
